sd_arbiter: RTL and testbench

Shares the single SD block-level port of the MiST IO controller between several disk-emulation requesters, such as the TR-DOS/Beta disk controller and a +3 FDC or DivMMC image. It sits between the requesters and the IO controller's `sd_lba`/`sd_rd`/`sd_wr`/`sd_ack` and `sd_buff_*` signals. It grants one sector transfer at a time, round-robin, and routes the sector-buffer byte stream to the granted requester only.

---
 rtl/sd_arbiter_pkg.sv | 20 ++
 rtl/sd_arbiter_rr_pick.sv | 38 +++
 rtl/sd_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_sd_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sd_arb_pkg
//   Shared types and widths for the SD block-port arbiter.
//   - sd_arb_state_t : arbiter FSM states (IDLE, ISSUE, XFER, DONE)
//   - SD_LBA_W       : sector address width on the IO-controller SD port
//   - SD_BYTE_W      : sector-buffer data width
// -----------------------------------------------------------------------------
package sd_arb_pkg;

    localparam int SD_LBA_W  = 32;
    localparam int SD_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no grant
        ISSUE = 2'd1,   // sd_rd/sd_wr asserted, waiting for sd_ack
        XFER  = 2'd2,   // sd_ack high, sector streaming
        DONE  = 2'd3    // release grant, advance priority pointer
    } sd_arb_state_t;

endpackage

// File: rtl/sd_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin selector. Searches the pending vector starting
//   at last+1 (mod NREQ) and returns the first pending index.
//   Ports:
//     pending_i  NREQ  pending requesters
//     last_i     IW    index served most recently
//     valid_o    1     at least one requester pending
//     g_o        IW    winning index (0 when valid_o is low)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] pending_i,
    input  logic [IW-1:0]   last_i,
    output logic            valid_o,
    output logic [IW-1:0]   g_o
);

    // Walk the distances from farthest to nearest so the nearest pending
    // requester (highest priority) is the last assignment and wins.
    always_comb begin
        // NOTE: defaults before any conditional assignment keep this block
        // purely combinational; a missing default would infer a latch.
        valid_o = 1'b0;
        g_o     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            int idx;
            idx = (int'(last_i) + k) % NREQ;
            if (pending_i[idx]) begin
                valid_o = 1'b1;
                g_o     = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/sd_arbiter.sv
// -----------------------------------------------------------------------------
// sd_arbiter
//   Shares the single SD block-level port of the IO controller between NREQ
//   disk-emulation requesters. One sector transfer is granted at a time in
//   round-robin order; the sector-buffer strobe and write data are routed to
//   and from the granted requester only, with zero added latency.
//
//   Optional feature: define SD_ARB_TIMEOUT_EN to enable the sd_ack watchdog.
//   When undefined, req_err is tied low and ISSUE waits indefinitely.
//
//   Ports:
//     clk_sys       in   system clock
//     rst_n         in   asynchronous active-low reset
//     req_lba       in   NREQ*32 per-requester LBA (slice i = requester i)
//     req_rd/req_wr in   NREQ    per-requester read/write request
//     req_ack       out  NREQ    sd_ack routed to the granted requester
//     req_err       out  NREQ    watchdog abort pulse
//     req_buff_wr   out  NREQ    sd_buff_wr routed to the granted requester
//     req_buff_din  in   NREQ*8  per-requester write-data byte
//     sd_lba        out  32      latched LBA to the IO controller
//     sd_rd/sd_wr   out  1       request to the IO controller
//     sd_ack        in   1       acknowledge from the IO controller
//     sd_buff_wr    in   1       sector-buffer write strobe
//     sd_buff_din   out  8       write data of the granted requester
// -----------------------------------------------------------------------------
module sd_arbiter
    import sd_arb_pkg::*;
#(
    parameter int          NREQ           = 2,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
    input  logic                      clk_sys,
    input  logic                      rst_n,
    input  logic [NREQ*SD_LBA_W-1:0]  req_lba,
    input  logic [NREQ-1:0]           req_rd,
    input  logic [NREQ-1:0]           req_wr,
    output logic [NREQ-1:0]           req_ack,
    output logic [NREQ-1:0]           req_err,
    output logic [NREQ-1:0]           req_buff_wr,
    input  logic [NREQ*SD_BYTE_W-1:0] req_buff_din,
    output logic [SD_LBA_W-1:0]       sd_lba,
    output logic                      sd_rd,
    output logic                      sd_wr,
    input  logic                      sd_ack,
    input  logic                      sd_buff_wr,
    output logic [SD_BYTE_W-1:0]      sd_buff_din
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Elaboration-time guards on the configuration.
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("sd_arbiter: NREQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES == 24'd0) begin : g_bad_timeout
        $error("sd_arbiter: TIMEOUT_CYCLES must be non-zero");
    end

    // Unpack the flat per-requester buses into indexable arrays.
    logic [SD_LBA_W-1:0]  lba_arr [NREQ];
    logic [SD_BYTE_W-1:0] din_arr [NREQ];
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign lba_arr[i] = req_lba[i*SD_LBA_W +: SD_LBA_W];
        assign din_arr[i] = req_buff_din[i*SD_BYTE_W +: SD_BYTE_W];
    end

    sd_arb_state_t         state_q;
    logic [IW-1:0]         g_q;
    logic [IW-1:0]         last_q;
    logic [SD_LBA_W-1:0]   lba_q;
    logic                  rd_q;
    logic                  wr_q;

    logic [NREQ-1:0]       pending_d;
    logic                  pick_valid_d;
    logic [IW-1:0]         pick_g_d;
    logic                  granted_live_d;
    logic                  timeout_d;

    assign pending_d      = req_rd | req_wr;
    assign granted_live_d = req_rd[g_q] | req_wr[g_q];

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .pending_i (pending_d),
        .last_i    (last_q),
        .valid_o   (pick_valid_d),
        .g_o       (pick_g_d)
    );

`ifdef SD_ARB_TIMEOUT_EN
    logic [23:0] cnt_q;

    // Fires on the TIMEOUT_CYCLES-th ISSUE cycle; a withdrawal or an ack in
    // the same cycle takes precedence.
    assign timeout_d = (state_q == ISSUE) && !sd_ack && granted_live_d &&
                       (cnt_q == TIMEOUT_CYCLES - 24'd1);

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == IDLE) begin
            cnt_q <= '0;
        end else if (state_q == ISSUE) begin
            cnt_q <= cnt_q + 24'd1;
        end
    end

    always_comb begin
        req_err = '0;
        if (timeout_d) begin
            req_err[g_q] = 1'b1;
        end
    end
`else
    assign timeout_d = 1'b0;
    assign req_err   = '0;
`endif

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            g_q     <= '0;
            last_q  <= IW'(NREQ - 1);   // requester 0 searched first
            lba_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples the pre-edge values, independent of order.
            case (state_q)
                IDLE: begin
                    if (pick_valid_d) begin
                        g_q     <= pick_g_d;
                        lba_q   <= lba_arr[pick_g_d];
                        // A simultaneous read stays pending for a later grant.
                        wr_q    <= req_wr[pick_g_d];
                        rd_q    <= ~req_wr[pick_g_d];
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (sd_ack) begin
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        state_q <= XFER;
                    end else if (!granted_live_d || timeout_d) begin
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        state_q <= DONE;
                    end
                end
                XFER: begin
                    if (!sd_ack) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    last_q  <= g_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sd_lba = lba_q;
    assign sd_rd  = rd_q;
    assign sd_wr  = wr_q;

    // Zero-latency routing to/from the granted requester only while a
    // transaction is live; an ack outside ISSUE/XFER goes nowhere.
    always_comb begin
        req_ack     = '0;
        req_buff_wr = '0;
        sd_buff_din = '0;
        if (state_q == ISSUE || state_q == XFER) begin
            req_ack[g_q]     = sd_ack;
            req_buff_wr[g_q] = sd_buff_wr;
            sd_buff_din      = din_arr[g_q];
        end
    end

endmodule

// File: tb/tb_sd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sd_arbiter
//   Self-checking bench for sd_arbiter with NREQ=2. Inputs are driven just
//   after the falling edge and outputs are compared 1 ns later, so registered
//   outputs show the state after the previous rising edge and combinational
//   routing shows the current inputs.
// -----------------------------------------------------------------------------
module tb_sd_arbiter;
    import sd_arb_pkg::*;

    localparam int NREQ = 2;

    logic               clk_sys = 1'b0;
    logic               rst_n   = 1'b0;
    logic [NREQ*32-1:0] req_lba;
    logic [NREQ-1:0]    req_rd  = '0;
    logic [NREQ-1:0]    req_wr  = '0;
    logic [NREQ-1:0]    req_ack;
    logic [NREQ-1:0]    req_err;
    logic [NREQ-1:0]    req_buff_wr;
    logic [NREQ*8-1:0]  req_buff_din;
    logic [31:0]        sd_lba;
    logic               sd_rd;
    logic               sd_wr;
    logic               sd_ack     = 1'b0;
    logic               sd_buff_wr = 1'b0;
    logic [7:0]         sd_buff_din;

    localparam logic [31:0] LBA0 = 32'h0000_1234;
    localparam logic [31:0] LBA1 = 32'hBEEF_0001;

    assign req_lba      = {LBA1, LBA0};
    assign req_buff_din = {8'hA5, 8'h5A};

    always #5 clk_sys = ~clk_sys;

    sd_arbiter #(
        .NREQ           (NREQ),
        .TIMEOUT_CYCLES (24'd100)
    ) dut (
        .clk_sys      (clk_sys),
        .rst_n        (rst_n),
        .req_lba      (req_lba),
        .req_rd       (req_rd),
        .req_wr       (req_wr),
        .req_ack      (req_ack),
        .req_err      (req_err),
        .req_buff_wr  (req_buff_wr),
        .req_buff_din (req_buff_din),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next();
        @(negedge clk_sys);
    endtask

    // Poll for sd_rd/sd_wr for at most 20 cycles.
    task automatic wait_issue();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            next();
            #1;
            if (sd_rd || sd_wr) begin
                got = 1'b1;
                break;
            end
        end
        check("wait_issue", 64'(got), 64'd1);
    endtask

    // Complete one grant; report which requester saw the ack.
    task automatic serve(output int who);
        wait_issue();
        sd_ack = 1'b1;
        #1;
        who = (req_ack == 2'b01) ? 0 : (req_ack == 2'b10) ? 1 : -1;
        next();
        sd_ack = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic        ack;
        logic        bw;
        logic        exp_rd;
        logic        exp_wr;
        logic [31:0] exp_lba;
        logic [1:0]  exp_ack;
        logic [1:0]  exp_bw;
        logic [7:0]  exp_din;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int who;
        int cnt0;
        int cnt1;

        // Contention from reset: requester 0 read, then requester 1 write.
        tbl[0]  = '{2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  2'b00, 2'b00, 8'h00};
        tbl[1]  = '{2'b01, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, LBA0,   2'b00, 2'b00, 8'h5A};
        tbl[2]  = '{2'b01, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, LBA0,   2'b01, 2'b01, 8'h5A};
        tbl[3]  = '{2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, LBA0,   2'b01, 2'b00, 8'h5A};
        tbl[4]  = '{2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, LBA0,   2'b00, 2'b00, 8'h5A};
        tbl[5]  = '{2'b00, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, LBA0,   2'b00, 2'b00, 8'h00};
        tbl[6]  = '{2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, LBA0,   2'b00, 2'b00, 8'h00};
        tbl[7]  = '{2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, LBA1,   2'b00, 2'b00, 8'hA5};
        tbl[8]  = '{2'b00, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, LBA1,   2'b10, 2'b10, 8'hA5};
        tbl[9]  = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, LBA1,   2'b10, 2'b00, 8'hA5};
        tbl[10] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, LBA1,   2'b00, 2'b00, 8'hA5};
        tbl[11] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, LBA1,   2'b00, 2'b00, 8'h00};
        tbl[12] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, LBA1,   2'b00, 2'b00, 8'h00};

        // Reset state.
        #12;
        check("rst_sd_rd",  64'(sd_rd),   64'd0);
        check("rst_sd_wr",  64'(sd_wr),   64'd0);
        check("rst_sd_lba", 64'(sd_lba),  64'd0);
        check("rst_req_err", 64'(req_err), 64'd0);
        next();
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            if (i != 0) next();
            req_rd     = tbl[i].rd;
            req_wr     = tbl[i].wr;
            sd_ack     = tbl[i].ack;
            sd_buff_wr = tbl[i].bw;
            #1;
            check($sformatf("v%0d_sd_rd", i),   64'(sd_rd),       64'(tbl[i].exp_rd));
            check($sformatf("v%0d_sd_wr", i),   64'(sd_wr),       64'(tbl[i].exp_wr));
            check($sformatf("v%0d_sd_lba", i),  64'(sd_lba),      64'(tbl[i].exp_lba));
            check($sformatf("v%0d_req_ack", i), 64'(req_ack),     64'(tbl[i].exp_ack));
            check($sformatf("v%0d_buff_wr", i), 64'(req_buff_wr), 64'(tbl[i].exp_bw));
            check($sformatf("v%0d_din", i),     64'(sd_buff_din), 64'(tbl[i].exp_din));
        end

        // Fairness: both continuously pending alternate 0,1,0,1.
        next();
        req_rd = 2'b11;
        for (int k = 0; k < 4; k++) begin
            serve(who);
            check($sformatf("rr_order_%0d", k), 64'(who), 64'(k % 2));
        end
        req_rd = 2'b00;
        repeat (3) next();

        // Single read with a 512-strobe sector.
        req_rd = 2'b01;
        #1;
        check("rd_lat_n", 64'(sd_rd), 64'd0);
        next();
        #1;
        check("rd_lat_n1", 64'(sd_rd), 64'd1);
        check("rd_lba",    64'(sd_lba), 64'(LBA0));
        next();
        sd_ack = 1'b1;
        req_rd = 2'b00;
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < 512; i++) begin
            sd_buff_wr = 1'b1;
            #1;
            cnt0 += int'(req_buff_wr[0]);
            cnt1 += int'(req_buff_wr[1]);
            next();
        end
        sd_buff_wr = 1'b0;
        sd_ack     = 1'b0;
        check("strobes_req0", 64'(cnt0), 64'd512);
        check("strobes_req1", 64'(cnt1), 64'd0);
        repeat (3) next();

        // Withdrawal in ISSUE.
        req_rd = 2'b01;
        next();
        #1;
        check("wd_issue", 64'(sd_rd), 64'd1);
        next();
        req_rd = 2'b00;
        next();
        #1;
        check("wd_rd_low", 64'(sd_rd), 64'd0);
        check("wd_done",   64'(dut.state_q), 64'(DONE));
        next();
        #1;
        check("wd_idle",   64'(dut.state_q), 64'(IDLE));

        // Read and write together: write first, read served next.
        next();
        req_rd = 2'b10;
        req_wr = 2'b10;
        next();
        #1;
        check("rw_sd_wr", 64'(sd_wr),  64'd1);
        check("rw_sd_rd", 64'(sd_rd),  64'd0);
        check("rw_lba",   64'(sd_lba), 64'(LBA1));
        next();
        sd_ack = 1'b1;
        req_wr = 2'b00;
        #1;
        check("rw_ack", 64'(req_ack), 64'd2);
        next();
        sd_ack = 1'b0;
        wait_issue();
        check("rw2_sd_rd", 64'(sd_rd),  64'd1);
        check("rw2_sd_wr", 64'(sd_wr),  64'd0);
        check("rw2_lba",   64'(sd_lba), 64'(LBA1));
        next();
        sd_ack = 1'b1;
        req_rd = 2'b00;
        next();
        sd_ack = 1'b0;
        repeat (3) next();

        // Watchdog.
        req_rd = 2'b01;
`ifdef SD_ARB_TIMEOUT_EN
        for (int k = 1; k <= 101; k++) begin
            next();
            #1;
            if (k == 99) check("wdog_err_99", 64'(req_err), 64'd0);
            if (k == 100) begin
                check("wdog_err_100", 64'(req_err), 64'd1);
                check("wdog_rd_100",  64'(sd_rd),   64'd1);
            end
            if (k == 101) begin
                check("wdog_rd_101",  64'(sd_rd),   64'd0);
                check("wdog_err_101", 64'(req_err), 64'd0);
            end
        end
        req_rd = 2'b00;
`else
        repeat (1000) next();
        #1;
        check("nowdog_rd_held", 64'(sd_rd),   64'd1);
        check("nowdog_err",     64'(req_err), 64'd0);
        req_rd = 2'b00;
        next();
        #1;
        check("nowdog_release", 64'(sd_rd), 64'd0);
`endif
        repeat (3) next();

        // Reset mid-XFER on a requester-1 transfer.
        req_rd = 2'b10;
        wait_issue();
        next();
        sd_ack     = 1'b1;
        sd_buff_wr = 1'b1;
        #1;
        check("rst_pre_ack", 64'(req_ack), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_sd_rd",   64'(sd_rd),       64'd0);
        check("arst_sd_wr",   64'(sd_wr),       64'd0);
        check("arst_lba",     64'(sd_lba),      64'd0);
        check("arst_req_ack", 64'(req_ack),     64'd0);
        check("arst_buff_wr", 64'(req_buff_wr), 64'd0);
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;
        req_rd     = 2'b11;
        next();
        rst_n = 1'b1;
        next();
        #1;
        check("post_rst_rd",  64'(sd_rd),  64'd1);
        check("post_rst_lba", 64'(sd_lba), 64'(LBA0));
        sd_ack = 1'b1;
        #1;
        check("post_rst_ack", 64'(req_ack), 64'd1);
        next();
        sd_ack = 1'b0;
        req_rd = 2'b00;
        repeat (3) next();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
